// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM for the stopwatch datapath.
// Two raw buttons (start/stop, zero/lap) are synchronized and debounced into
// single-cycle press pulses. Those pulses drive a 4-state Moore FSM that
// enables/clears the delay counter and selects a live or lap-frozen count for
// the display path.
// Optional feature macro: STOPWATCH_AUTOSTOP_EN (auto-pause at AUTOSTOP_LIMIT
// with a sticky overflow flag). Without it, overflow is tied low and the
// count wraps freely.

// Per-button conditioning: 2-flop synchronizer, stable-count debouncer and
// rising-edge press detector.
module stopwatch_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  // Synchronize, then accept a new level only after it has been seen
  // DEBOUNCE_CYCLES samples in a row; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      if (sync[1] != stable) begin
        if (cnt == LAST) begin
          stable <= sync[1];
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One pulse per accepted press; releases are ignored.
  assign press = stable & ~stable_q;

endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int COUNT_W         = 15,
  parameter int AUTOSTOP_LIMIT  = 9999
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start_stop,
  input  logic               btn_zero_lap,
  input  logic [COUNT_W-1:0] counter,
  output logic               contar_tempo,
  output logic               zerar_tempo,
  output logic [COUNT_W-1:0] display_value,
  output logic               lap_active,
  output logic [1:0]         state,
  output logic               overflow
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] RUN   = 2'b01;
  localparam logic [1:0] PAUSE = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int NUM_BTN = 2;
  localparam int BTN_SS  = 0;
  localparam int BTN_ZL  = 1;

  localparam logic [COUNT_W-1:0] LIMIT = COUNT_W'(AUTOSTOP_LIMIT);

`ifdef STOPWATCH_AUTOSTOP_EN
  localparam bit AUTOSTOP_EN = 1'b1;
`else
  localparam bit AUTOSTOP_EN = 1'b0;
`endif

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] press;
  logic [1:0]         next_state;
  logic [COUNT_W-1:0] lap_reg;
  logic               lap_load;
  logic               counting;
  logic               autostop;

  assign raw = {btn_zero_lap, btn_start_stop};

  genvar g;
  generate
    for (g = 0; g < NUM_BTN; g++) begin : g_btn
      stopwatch_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .raw   (raw[g]),
        .press (press[g])
      );
    end
  endgenerate

  assign counting = (state == RUN) || (state == LAP);
  // Limit hit pre-empts any press in the same cycle.
  assign autostop = AUTOSTOP_EN && counting && (counter == LIMIT);

  // Next-state logic; start_stop has priority and a losing zero_lap is dropped.
  always_comb begin
    next_state = state;
    lap_load   = 1'b0;
    if (autostop) begin
      next_state = PAUSE;
    end else begin
      case (state)
        IDLE: begin
          if (press[BTN_SS]) next_state = RUN;
        end
        RUN: begin
          if (press[BTN_SS]) begin
            next_state = PAUSE;
          end else if (press[BTN_ZL]) begin
            next_state = LAP;
            lap_load   = 1'b1;
          end
        end
        LAP: begin
          if (press[BTN_SS])      next_state = PAUSE;
          else if (press[BTN_ZL]) next_state = RUN;
        end
        PAUSE: begin
          if (press[BTN_SS])      next_state = RUN;
          else if (press[BTN_ZL]) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register; reset wins over any press in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Lap register captures the live count on RUN->LAP and otherwise holds.
  always_ff @(posedge clk) begin
    if (reset)         lap_reg <= '0;
    else if (lap_load) lap_reg <= counter;
  end

`ifdef STOPWATCH_AUTOSTOP_EN
  // Sticky auto-stop flag, cleared only when the FSM enters IDLE.
  always_ff @(posedge clk) begin
    if (reset)                                   overflow <= 1'b0;
    else if (next_state == IDLE && state != IDLE) overflow <= 1'b0;
    else if (autostop)                           overflow <= 1'b1;
  end
`else
  assign overflow = 1'b0;
`endif

  // Moore output decode, no extra register stage.
  assign contar_tempo  = counting;
  assign zerar_tempo   = (state == IDLE);
  assign lap_active    = (state == LAP);
  assign display_value = (state == LAP) ? lap_reg : counter;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4 (press latency 7).
module tb_stopwatch_ctrl;

  localparam int N  = 4;
  localparam int CW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_start_stop = 1'b0;
  logic          btn_zero_lap = 1'b0;
  logic [CW-1:0] counter = '0;
  logic          contar_tempo;
  logic          zerar_tempo;
  logic [CW-1:0] display_value;
  logic          lap_active;
  logic [1:0]    state;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(N), .COUNT_W(CW), .AUTOSTOP_LIMIT(9999)) dut (
    .clk            (clk),
    .reset          (reset),
    .btn_start_stop (btn_start_stop),
    .btn_zero_lap   (btn_zero_lap),
    .counter        (counter),
    .contar_tempo   (contar_tempo),
    .zerar_tempo    (zerar_tempo),
    .display_value  (display_value),
    .lap_active     (lap_active),
    .state          (state),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a button until its press lands (edge N+3), then release and settle.
  task automatic press(input bit zl);
    if (zl) btn_zero_lap = 1'b1; else btn_start_stop = 1'b1;
    repeat (N + 3) tick();
    btn_zero_lap   = 1'b0;
    btn_start_stop = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; counter = 15'd55;
    repeat (2) tick();
    checks++;
    if (state !== 2'b00 || contar_tempo !== 1'b0 || zerar_tempo !== 1'b1 ||
        lap_active !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: state=%b contar=%b zerar=%b lap=%b ovf=%b, want 00 0 1 0 0",
               state, contar_tempo, zerar_tempo, lap_active, overflow);
    end
    checks++;
    if (display_value !== 15'd55) begin
      errors++;
      $display("FAIL reset_display: got %0d want 55", display_value);
    end
    reset = 1'b0; counter = '0;
    tick();
  endtask

  task automatic test_start_latency();
    btn_start_stop = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      checks++;
      if (state !== ((e >= 7) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL start_latency edge %0d: state=%b want %b", e, state, (e >= 7) ? 2'b01 : 2'b00);
      end
      if (e == 7) begin
        checks++;
        if (contar_tempo !== 1'b1 || zerar_tempo !== 1'b0) begin
          errors++;
          $display("FAIL run_enables: contar=%b zerar=%b want 1 0", contar_tempo, zerar_tempo);
        end
      end
    end
    btn_start_stop = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_glitch();
    for (int b = 0; b < 2; b++) begin
      for (int len = 1; len <= 3; len++) begin
        for (int rep = 0; rep < 2; rep++) begin
          if (b == 0) btn_start_stop = 1'b1; else btn_zero_lap = 1'b1;
          repeat (len) tick();
          btn_start_stop = 1'b0; btn_zero_lap = 1'b0;
          repeat (2) tick();
        end
        repeat (8) tick();
        checks++;
        if (state !== 2'b01 || lap_active !== 1'b0) begin
          errors++;
          $display("FAIL glitch btn%0d len%0d: state=%b lap=%b want 01 0", b, len, state, lap_active);
        end
      end
    end
  endtask

  task automatic test_lap();
    counter = 15'd123;
    btn_zero_lap = 1'b1;
    repeat (N + 3) tick();
    checks++;
    if (state !== 2'b11 || lap_active !== 1'b1 || display_value !== 15'd123 || contar_tempo !== 1'b1) begin
      errors++;
      $display("FAIL lap_enter: state=%b lap=%b disp=%0d contar=%b want 11 1 123 1",
               state, lap_active, display_value, contar_tempo);
    end
    for (int v = 124; v <= 130; v++) begin
      counter = CW'(v);
      tick();
      checks++;
      if (display_value !== 15'd123 || state !== 2'b11) begin
        errors++;
        $display("FAIL lap_frozen cnt=%0d: disp=%0d state=%b want 123 11", v, display_value, state);
      end
    end
    btn_zero_lap = 1'b0;
    repeat (12) tick();
    checks++;
    if (state !== 2'b11 || display_value !== 15'd123) begin
      errors++;
      $display("FAIL lap_release: state=%b disp=%0d want 11 123", state, display_value);
    end
    counter = 15'd131;
    press(1'b1);
    checks++;
    if (state !== 2'b01 || lap_active !== 1'b0 || display_value !== 15'd131) begin
      errors++;
      $display("FAIL lap_exit: state=%b lap=%b disp=%0d want 01 0 131", state, lap_active, display_value);
    end
    counter = 15'd140;
    #1;
    checks++;
    if (display_value !== 15'd140) begin
      errors++;
      $display("FAIL live_count: disp=%0d want 140", display_value);
    end
  endtask

  task automatic test_pause_idle();
    press(1'b0);
    checks++;
    if (state !== 2'b10 || contar_tempo !== 1'b0 || zerar_tempo !== 1'b0) begin
      errors++;
      $display("FAIL pause: state=%b contar=%b zerar=%b want 10 0 0", state, contar_tempo, zerar_tempo);
    end
    press(1'b1);
    checks++;
    if (state !== 2'b00 || contar_tempo !== 1'b0 || zerar_tempo !== 1'b1) begin
      errors++;
      $display("FAIL idle: state=%b contar=%b zerar=%b want 00 0 1", state, contar_tempo, zerar_tempo);
    end
    press(1'b1);
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL idle_zero_noop: state=%b want 00", state);
    end
    press(1'b0);
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL idle_restart: state=%b want 01", state);
    end
  endtask

  task automatic test_simultaneous();
    btn_start_stop = 1'b1; btn_zero_lap = 1'b1;
    repeat (N + 3) tick();
    checks++;
    if (state !== 2'b10) begin
      errors++;
      $display("FAIL both_in_run: state=%b want 10", state);
    end
    btn_start_stop = 1'b0; btn_zero_lap = 1'b0;
    repeat (12) tick();
    btn_start_stop = 1'b1; btn_zero_lap = 1'b1;
    repeat (N + 3) tick();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL both_in_pause: state=%b want 01", state);
    end
    repeat (3) tick();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL zero_lap_not_queued: state=%b want 01", state);
    end
    btn_start_stop = 1'b0; btn_zero_lap = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_autostop();
    counter = 15'd9999;
    tick();
`ifdef STOPWATCH_AUTOSTOP_EN
    checks++;
    if (state !== 2'b10 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL autostop_hit: state=%b ovf=%b want 10 1", state, overflow);
    end
    counter = 15'd0;
    press(1'b1);
    checks++;
    if (state !== 2'b00 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL autostop_clear: state=%b ovf=%b want 00 0", state, overflow);
    end
`else
    checks++;
    if (state !== 2'b01 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL no_autostop: state=%b ovf=%b want 01 0", state, overflow);
    end
    counter = 15'd0;
`endif
  endtask

  task automatic test_reset_hold();
    reset = 1'b1; btn_start_stop = 1'b1;
    tick();
    checks++;
    if (state !== 2'b00 || zerar_tempo !== 1'b1) begin
      errors++;
      $display("FAIL reset_midop: state=%b zerar=%b want 00 1", state, zerar_tempo);
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (N + 2) tick();
    checks++;
    if (state !== 2'b00) begin
      errors++;
      $display("FAIL held_early: state=%b want 00", state);
    end
    tick();
    checks++;
    if (state !== 2'b01) begin
      errors++;
      $display("FAIL held_through_reset: state=%b want 01", state);
    end
    btn_start_stop = 1'b0;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_glitch();
    test_lap();
    test_pause_idle();
    test_simultaneous();
    test_autostop();
    test_reset_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath. Synchronizes and debounces the two raw push-buttons (start/stop and zero/lap). Drives the `contar_tempo`/`zerar_tempo` enables of the tick counter. Selects a live or lap-frozen count for the display path, sitting between the board buttons and the delay counter / display decoder.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples needed to accept a button level change (10 ms at 50 MHz); legal range ≥ 1.
- `COUNT_W`, default 15: width of the count from the delay counter.
- `AUTOSTOP_LIMIT`, default 9999: count value that triggers auto-stop (only with `STOPWATCH_AUTOSTOP_EN`).

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `btn_start_stop` in 1: raw asynchronous button, active-high.
- `btn_zero_lap` in 1: raw asynchronous button, active-high.
- `counter` in COUNT_W: current count from the delay counter.
- `contar_tempo` out 1: count enable to the delay counter.
- `zerar_tempo` out 1: clear to the delay counter.
- `display_value` out COUNT_W: value for the display path.
- `lap_active` out 1: high while the display is frozen on a lap value.
- `state` out 2: FSM state encoding, for debug and LEDs.
- `overflow` out 1: sticky auto-stop flag.

## Operation
- Per button: 2-flop synchronizer, then stable-count debouncer.
  - If the synchronized level differs from `stable`, increment the count.
  - When the count reaches DEBOUNCE_CYCLES-1 with the level still different, load `stable` and clear the count.
  - Any sample equal to `stable` clears the count (glitch rejection).
- Press pulse = rising edge of `stable`; exactly one cycle per accepted press. Releases generate nothing.
- FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
  - IDLE: start_stop → RUN; zero_lap → IDLE (no effect).
  - RUN: start_stop → PAUSE; zero_lap → LAP, capturing `counter` into the lap register on the same edge.
  - LAP: start_stop → PAUSE; zero_lap → RUN.
  - PAUSE: start_stop → RUN; zero_lap → IDLE.
- Simultaneous press pulses in one cycle: start_stop wins; zero_lap is discarded, not queued.
- Outputs are a Moore decode of `state`:
  - `contar_tempo` = 1 in RUN and LAP.
  - `zerar_tempo` = 1 in IDLE only. It is held for the whole IDLE stay, so the counter clears regardless of its internal prescaler phase.
  - `lap_active` = 1 in LAP.
  - `display_value` = lap register in LAP, otherwise `counter`.
- The lap register holds its value until the next RUN→LAP capture; it is never cleared except by reset.

## Timing
- Reset values:
  - `state` = IDLE, so `contar_tempo` = 0, `zerar_tempo` = 1, `lap_active` = 0.
  - Lap register = 0, `overflow` = 0.
  - Synchronizers, `stable` and debounce counts = 0.
  - `display_value` follows `counter`.
- Reset mid-operation forces IDLE on that edge; any press pulse in the same cycle is ignored.
- A button held through reset is accepted as a fresh press DEBOUNCE_CYCLES+3 edges after reset deasserts.
- Press latency: edge 1 is the first edge sampling the raw input high; an input held stable changes `state` on edge DEBOUNCE_CYCLES+3.
  - `contar_tempo`/`zerar_tempo` change in the same cycle as `state`, with no extra register stage.
- The count keeps advancing in LAP; leaving LAP re-exposes the live count immediately.
- The delay counter's own wrap at 10000 is not interpreted here.

## Configuration
- Macro: `STOPWATCH_AUTOSTOP_EN`.
- Defined:
  - In RUN or LAP, `counter == AUTOSTOP_LIMIT` forces PAUSE on the next edge and sets `overflow`.
  - A start_stop press in the same cycle is dropped.
  - `overflow` clears only on entry to IDLE or on reset.
  - PAUSE→RUN while `counter` is still at the limit re-triggers the stop one edge later.
- Undefined: no limit check; `overflow` is tied to 0; counting wraps freely.

## Test plan
(Bench uses DEBOUNCE_CYCLES=4.)
- Reset, then hold `btn_start_stop` high 10 cycles → `state` 00→01 on edge 7 after the first high sample; `contar_tempo`=1, `zerar_tempo`=0.
- Raw button pulses of 1–3 cycles, repeated → no state change, no press pulse.
- RUN with `counter`=123, press zero_lap → LAP; `display_value` stays 123 while `counter` advances to 130; second zero_lap → RUN, `display_value` = live count.
- RUN → PAUSE → zero_lap → IDLE → `zerar_tempo`=1, `contar_tempo`=0; release and re-press start → RUN.
- Both buttons accepted in the same cycle while in RUN → PAUSE only; in PAUSE → RUN only.
- With `STOPWATCH_AUTOSTOP_EN`, drive `counter`=9999 in RUN → next edge PAUSE, `overflow`=1; zero_lap → IDLE, `overflow`=0. Without the macro → stays RUN, `overflow`=0.
